// File: rtl/led_mode_select_if.sv
// LED board mode-select bundle: pattern driver inputs toward the selector and
// the muxed LED drive, mode index and driver restart back out.
interface led_mode_select_if;
  logic [7:0] mode0_led;
  logic [7:0] mode1_led;
  logic [7:0] mode2_led;
  logic [7:0] mode3_led;
  logic [7:0] led_out;
  logic [1:0] mode;
  logic       mode_changed;
  logic       mode_rst_n;

  modport master (
    output mode0_led, mode1_led, mode2_led, mode3_led,
    input  led_out, mode, mode_changed, mode_rst_n
  );

  modport slave (
    input  mode0_led, mode1_led, mode2_led, mode3_led,
    output led_out, mode, mode_changed, mode_rst_n
  );
endinterface

// File: rtl/led_mode_select.sv
// Debounces the mode button, steps the mode index on each accepted press and
// muxes the selected pattern driver onto the LEDs with a blank/restart window.
//
// state   | meaning
// S_IDLE  | button released and stable
// S_PRESS | low seen, counting stable low samples
// S_HELD  | press accepted, waiting for release
// S_REL   | high seen, counting stable high samples
module led_mode_select #(
  parameter int NUM_MODES    = 4,
  parameter int DEB_CYCLES   = 20,
  parameter int BLANK_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_n,
  led_mode_select_if.slave   led_if
);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD, S_REL} state_e;

  localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] BLANK_LEN = 16'(BLANK_CYCLES);
  localparam logic [1:0]  MODE_LAST = 2'(NUM_MODES - 1);

  state_e      state_q, state_d;
  logic [15:0] dc_q, dc_d;
  logic [15:0] bc_q, bc_d;
  logic        sync1_q, ks_q;
  logic [1:0]  mode_q, mode_d;
  logic        mode_changed_q;
  logic [7:0]  led_q, led_d, sel_led;
  logic        mode_rst_n_q;
  logic        accept;
  logic        blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      ks_q    <= 1'b1;
    end else begin
      sync1_q <= key_n;
      ks_q    <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dc_q           <= '0;
      bc_q           <= '0;
      mode_q         <= '0;
      mode_changed_q <= 1'b0;
      led_q          <= '0;
      mode_rst_n_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      dc_q           <= dc_d;
      bc_q           <= bc_d;
      mode_q         <= mode_d;
      mode_changed_q <= accept;
      led_q          <= led_d;
      mode_rst_n_q   <= ~blank;
    end
  end

  always_comb begin
    state_d = state_q;
    dc_d    = dc_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ks_q) begin
          dc_d    = 16'd1;
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        if (ks_q) begin
          dc_d    = '0;
          state_d = S_IDLE;
        end else if (dc_q == DEB_LAST) begin
          accept  = 1'b1;
          dc_d    = '0;
          state_d = S_HELD;
        end else begin
          dc_d = dc_q + 16'd1;
        end
      end
      S_HELD: begin
        if (ks_q) begin
          dc_d    = 16'd1;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (!ks_q) begin
          dc_d    = '0;
          state_d = S_HELD;
        end else if (dc_q == DEB_LAST) begin
          dc_d    = '0;
          state_d = S_IDLE;
        end else begin
          dc_d = dc_q + 16'd1;
        end
      end
      default: begin
        dc_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Blank while the next counter value is nonzero: the accept cycle itself plus
  // BLANK_CYCLES-1 decrements gives exactly BLANK_CYCLES dark cycles.
  always_comb begin
    mode_d = mode_q;
    if (accept) begin
      mode_d = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;
    end

    if (accept) begin
      bc_d = BLANK_LEN;
    end else if (bc_q != 16'd0) begin
      bc_d = bc_q - 16'd1;
    end else begin
      bc_d = '0;
    end
    blank = (bc_d != 16'd0);

    case (mode_q)
      2'd0:    sel_led = led_if.mode0_led;
      2'd1:    sel_led = led_if.mode1_led;
      2'd2:    sel_led = led_if.mode2_led;
      default: sel_led = led_if.mode3_led;
    endcase
    if (int'(mode_q) >= NUM_MODES) begin
      sel_led = '0;
    end

    led_d = blank ? 8'h00 : sel_led;
  end

  assign led_if.led_out      = led_q;
  assign led_if.mode         = mode_q;
  assign led_if.mode_changed = mode_changed_q;
  assign led_if.mode_rst_n   = mode_rst_n_q;

endmodule

// File: tb/tb_led_mode_select.sv
// Directed bench for led_mode_select: two instances (4 and 3 modes) share the
// button; accepted presses are scoreboarded with their expected mode and edge.
module tb_led_mode_select;

  logic clk;
  logic rst_n;
  logic key_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  logic [1:0] m4, m3;

  typedef struct {
    logic [1:0] mode;
    int         at;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  led_mode_select_if if4();
  led_mode_select_if if3();

  led_mode_select #(.NUM_MODES(4), .DEB_CYCLES(20), .BLANK_CYCLES(8)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .led_if (if4)
  );

  led_mode_select #(.NUM_MODES(3), .DEB_CYCLES(20), .BLANK_CYCLES(8)) dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .led_if (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_led(input int idx, input logic [7:0] v);
    case (idx)
      0: begin if4.mode0_led = v; if3.mode0_led = v; end
      1: begin if4.mode1_led = v; if3.mode1_led = v; end
      2: begin if4.mode2_led = v; if3.mode2_led = v; end
      default: begin if4.mode3_led = v; if3.mode3_led = v; end
    endcase
  endtask

  task automatic expect_accept(input int at);
    exp_t e;
    m4 = (m4 == 2'd3) ? 2'd0 : m4 + 2'd1;
    m3 = (m3 == 2'd2) ? 2'd0 : m3 + 2'd1;
    e.at = at;
    e.mode = m4;
    q4.push_back(e);
    e.mode = m3;
    q3.push_back(e);
  endtask

  task automatic press(input int hold, input int rel);
    key_n = 1'b0;
    expect_accept(cyc + 22);
    step(hold);
    key_n = 1'b1;
    step(rel);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if4.mode_changed === 1'b1) begin
      chk("pulse4_expected", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("mode4", 32'(if4.mode), 32'(e.mode));
        chk("edge4", cyc, e.at);
      end
    end
    if (if3.mode_changed === 1'b1) begin
      chk("pulse3_expected", 32'(q3.size() > 0), 32'd1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("mode3", 32'(if3.mode), 32'(e.mode));
        chk("edge3", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    m4     = 2'd0;
    m3     = 2'd0;
    rst_n  = 1'b0;
    key_n  = 1'b1;
    set_led(0, 8'h3C);
    set_led(1, 8'hA5);
    set_led(2, 8'hC3);
    set_led(3, 8'h0F);

    #2;
    chk("rst_led", 32'(if4.led_out), 32'h00);
    chk("rst_mode", 32'(if4.mode), 32'd0);
    chk("rst_mode_rst_n", 32'(if4.mode_rst_n), 32'd0);
    chk("rst_mode_changed", 32'(if4.mode_changed), 32'd0);

    @(negedge clk);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("first_edge_mode_rst_n", 32'(if4.mode_rst_n), 32'd1);
    chk("idle_led_mode0", 32'(if4.led_out), 32'h3C);
    chk("idle_mode", 32'(if4.mode), 32'd0);

    set_led(0, 8'h5A);
    step(1);
    chk("mux_latency", 32'(if4.led_out), 32'h5A);

    // clean press with full blank-window walk
    key_n = 1'b0;
    expect_accept(cyc + 22);
    step(22);
    chk("accept_strobe", 32'(if4.mode_changed), 32'd1);
    chk("accept_mode", 32'(if4.mode), 32'd1);
    chk("blank_led_first", 32'(if4.led_out), 32'h00);
    chk("blank_rst_first", 32'(if4.mode_rst_n), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step(1);
      chk("blank_led", 32'(if4.led_out), 32'h00);
      chk("blank_rst", 32'(if4.mode_rst_n), 32'd0);
      chk("single_strobe", 32'(if4.mode_changed), 32'd0);
    end
    step(1);
    chk("post_blank_led", 32'(if4.led_out), 32'hA5);
    chk("post_blank_rst", 32'(if4.mode_rst_n), 32'd1);
    step(10);
    key_n = 1'b1;
    step(30);

    // press bounce: timing counts from the second fall
    key_n = 1'b0;
    step(10);
    key_n = 1'b1;
    step(3);
    key_n = 1'b0;
    expect_accept(cyc + 22);
    step(30);
    key_n = 1'b1;
    step(30);
    chk("bounce_mode4", 32'(if4.mode), 32'(m4));

    // one sample short of DEB_CYCLES: rejected
    key_n = 1'b0;
    step(19);
    key_n = 1'b1;
    step(30);
    chk("short_pulse_mode4", 32'(if4.mode), 32'(m4));
    chk("short_pulse_mode3", 32'(if3.mode), 32'(m3));

    // release bounce, then a normal press
    key_n = 1'b0;
    expect_accept(cyc + 22);
    step(30);
    key_n = 1'b1;
    step(10);
    key_n = 1'b0;
    step(2);
    key_n = 1'b1;
    step(30);
    press(30, 30);
    chk("rel_bounce_mode4", 32'(if4.mode), 32'(m4));
    chk("rel_bounce_mode3", 32'(if3.mode), 32'(m3));

    // reset in the middle of a blank window
    key_n = 1'b0;
    expect_accept(cyc + 22);
    step(25);
    rst_n = 1'b0;
    key_n = 1'b1;
    #1;
    chk("async_rst_led", 32'(if4.led_out), 32'h00);
    chk("async_rst_mode", 32'(if4.mode), 32'd0);
    chk("async_rst_mode_rst_n", 32'(if4.mode_rst_n), 32'd0);
    m4 = 2'd0;
    m3 = 2'd0;
    @(negedge clk);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rerelease_mode_rst_n", 32'(if4.mode_rst_n), 32'd1);
    chk("rerelease_led", 32'(if4.led_out), 32'h5A);
    step(40);
    chk("rerelease_mode", 32'(if4.mode), 32'd0);

    // five clean presses: 1,2,3,0,1 and 1,2,0,1,2 via the scoreboard
    repeat (5) press(30, 30);
    chk("final_mode4", 32'(if4.mode), 32'd1);
    chk("final_mode3", 32'(if3.mode), 32'd2);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_mode_select.md
# led_mode_select

Front-end mode controller for the LED board. It debounces the active-low mode push button and steps a mode index on each confirmed press, wrapping at `NUM_MODES`. It restarts the LED pattern drivers (running light, breathing, and the rest) through a shared reset strobe, and muxes the selected driver's 8-bit pattern onto the board LEDs. It sits between the button pin and the pattern drivers on the input side, and between the drivers and the LED pins on the output side.

## Interface
Parameters:
- `NUM_MODES`, default 4: number of active modes, legal range 1..4. Inputs for modes at or above `NUM_MODES` are ignored.
- `DEB_CYCLES`, default 20: consecutive stable samples needed to accept a level change. Legal range 2..65535.
- `BLANK_CYCLES`, default 8: length of the LED blank and driver-reset window after a mode change. Legal range 1..65535.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `key_n`, input, 1: raw mode button. 0 = pressed. Asynchronous to `clk`.
- `mode0_led` … `mode3_led`, input, 8 each: pattern driver outputs.
- `led_out`, output, 8: registered LED drive.
- `mode`, output, 2: current mode index.
- `mode_changed`, output, 1: one-cycle strobe in the cycle `mode` takes its new value.
- `mode_rst_n`, output, 1: registered active-low restart for the pattern drivers.

## Operation
- Reset is asynchronous and active-low. Reset values:
  - 2-FF synchronizer = 1,1
  - state = S_IDLE, debounce counter = 0, blank counter = 0
  - `mode` = 0, `mode_changed` = 0, `led_out` = 0, `mode_rst_n` = 0
- `mode_rst_n` goes to 1 on the first clock edge after reset release, unless a blank window is active.
- `key_n` passes through a 2-FF synchronizer. All logic below uses only the synchronized level `ks`.
- Debounce FSM, 16-bit counter `dc`:
  - S_IDLE: if `ks`=0, then `dc`←1 and go to S_PRESS.
  - S_PRESS:
    - `ks`=1: `dc`←0, go to S_IDLE. This is a glitch and is rejected.
    - `ks`=0 and `dc`=`DEB_CYCLES`-1: accept the press, `dc`←0, go to S_HELD.
    - Otherwise `dc`++.
  - S_HELD: if `ks`=1, then `dc`←1 and go to S_REL.
  - S_REL:
    - `ks`=0: `dc`←0, go to S_HELD.
    - `ks`=1 and `dc`=`DEB_CYCLES`-1: `dc`←0, go to S_IDLE.
    - Otherwise `dc`++.
- Accepting a press:
  - `mode` ← (`mode`=`NUM_MODES`-1) ? 0 : `mode`+1.
  - `mode_changed` pulses.
  - Blank counter is loaded with `BLANK_CYCLES`.
  - With `NUM_MODES`=1, `mode` stays 0, but the strobe and blank window still occur.
- Blank window, active while the blank counter ≠ 0:
  - `led_out` ← 0 and `mode_rst_n` ← 0.
  - The counter decrements each cycle.
  - A new accept during the window reloads the counter to `BLANK_CYCLES`; the window is not extended additively.
- Outside the window: `led_out` ← `modeN_led` selected by `mode`, and `mode_rst_n` ← 1.
- If the button is held through reset release, `ks` falls 2 cycles after release and is debounced as a normal press.

## Timing
- Synchronizer latency: 2 cycles from a `key_n` edge to a `ks` change.
- Press latency: the accept happens on the `DEB_CYCLES`-th consecutive low `ks` sample. `mode` and `mode_changed` are updated at the following edge, so `mode` changes `DEB_CYCLES`+2 edges after `key_n` falls cleanly.
- `mode_rst_n` and `led_out` are low for exactly `BLANK_CYCLES` cycles, starting in the same cycle `mode_changed` is high.
- At the first edge after the window, `led_out` shows the new mode's input and `mode_rst_n`=1.
- Mux latency: 1 cycle from `modeN_led` to `led_out`.
- Minimum press-to-press interval: 2·`DEB_CYCLES` cycles of stable levels, plus 4 cycles of sync and transition.
- `mode_changed` is never high for 2 consecutive cycles.

## Test plan
- Reset, then `key_n`=1 and `mode1_led`=8'hA5 → `mode`=0 and `led_out` follows `mode0_led` after 1 cycle. `mode_rst_n`=1 after the first edge.
- Clean press held for 40 cycles with `DEB_CYCLES`=20 → exactly one `mode_changed` pulse, 22 edges after the fall. `mode`=1. `led_out`=0 and `mode_rst_n`=0 for 8 cycles, then `led_out`=8'hA5.
- Bounce: `key_n` low for 10 cycles, high for 3, low for 30 → a single accept, timed from the second fall. A 19-cycle low pulse → no change.
- 5 clean press/release pairs with `NUM_MODES`=4 → `mode` sequence 1,2,3,0,1. With `NUM_MODES`=3 → 1,2,0,1,2.
- Release bounce: high for 10 cycles, low for 2, then stable high → no extra accept. The next press is accepted normally.
- `rst_n` pulled low mid-blank → `led_out`=0, `mode`=0, `mode_rst_n`=0 immediately, without waiting for a clock edge. After release, no pending blank and no pulse.
